// File: rtl/controle_tempo_jogada_pkg.sv
// controle_tempo_jogada_pkg: state codes and debug width shared by the round-timing control unit
package controle_tempo_jogada_pkg;
    localparam int DB_W = 4;
    typedef enum logic [DB_W-1:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        CONTANDO = 4'd2,
        PAUSADO  = 4'd3,
        ACERTO   = 4'd4,
        ESTOURO  = 4'd5,
        FIM_JOGO = 4'd15
    } estado_t;
endpackage

// File: rtl/controle_tempo_jogada.sv
// controle_tempo_jogada: round window timing, sticky time warnings and consecutive overrun counting
module controle_tempo_jogada
    import controle_tempo_jogada_pkg::*;
#(
    parameter int MAX_ESTOUROS = 3,
    parameter int NE = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            iniciar,
    input  logic            jogada,
    input  logic            pausa,
    input  logic            fim,
    input  logic            meio,
    input  logic            quarto,
    output logic            conta,
    output logic            zera_s,
    output logic            alerta_quarto,
    output logic            alerta_meio,
    output logic            pronto,
    output logic            timeout,
    output logic            fim_jogo,
    output logic [NE-1:0]   estouros,
    output logic [DB_W-1:0] db_estado
);
    localparam logic [NE-1:0] MAX_E = NE'(MAX_ESTOUROS);
    estado_t estado, proximo;
    logic [NE-1:0] estouros_inc;
    logic inicio_aceito;
    assign estouros_inc  = estouros == MAX_E ? estouros : estouros + 1'b1;
    assign inicio_aceito = iniciar && (estado == INICIAL || estado == FIM_JOGO);
    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:  proximo = iniciar ? PREPARA : INICIAL;
            PREPARA:  proximo = CONTANDO;
            CONTANDO: proximo = jogada ? ACERTO : fim ? ESTOURO : pausa ? PAUSADO : CONTANDO;
            PAUSADO:  proximo = pausa ? PAUSADO : CONTANDO;
            ACERTO:   proximo = PREPARA;
            ESTOURO:  proximo = estouros_inc == MAX_E ? FIM_JOGO : PREPARA;
            FIM_JOGO: proximo = iniciar ? PREPARA : FIM_JOGO;
            default:  proximo = INICIAL;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end
    assign zera_s    = estado == PREPARA;
    assign conta     = estado == CONTANDO;
    assign pronto    = estado == ACERTO;
    assign timeout   = estado == ESTOURO;
    assign fim_jogo  = estado == FIM_JOGO;
    assign db_estado = estado;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alerta_quarto <= 1'b0;
            alerta_meio   <= 1'b0;
            estouros      <= '0;
        end else begin
            if (estado == PREPARA) begin
                alerta_quarto <= 1'b0;
                alerta_meio   <= 1'b0;
            end else if (estado == CONTANDO) begin
                if (quarto) alerta_quarto <= 1'b1;
                if (meio)   alerta_meio   <= 1'b1;
            end
            if (estado == ESTOURO)                   estouros <= estouros_inc;
            else if (estado == ACERTO || inicio_aceito) estouros <= '0;
        end
    end
endmodule

// File: tb/tb_controle_tempo_jogada.sv
// tb_controle_tempo_jogada: directed checks of the round-timing unit driving a modulo-8 counter
module tb_controle_tempo_jogada;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0, jogada = 1'b0, pausa = 1'b0;
    logic fim, meio, quarto;
    logic conta, zera_s, alerta_quarto, alerta_meio, pronto, timeout, fim_jogo;
    logic [1:0] estouros;
    logic [3:0] db_estado;
    logic [2:0] q;
    int checks = 0;
    int errors = 0;
    int n;
    logic aq_antes, am_antes;

    controle_tempo_jogada #(.MAX_ESTOUROS(3), .NE(2)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .pausa(pausa),
        .fim(fim), .meio(meio), .quarto(quarto), .conta(conta), .zera_s(zera_s),
        .alerta_quarto(alerta_quarto), .alerta_meio(alerta_meio), .pronto(pronto),
        .timeout(timeout), .fim_jogo(fim_jogo), .estouros(estouros), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       q <= '0;
        else if (zera_s) q <= '0;
        else if (conta)  q <= q + 3'd1;
    end
    assign fim    = q == 3'd7;
    assign meio   = q == 3'd3;
    assign quarto = q == 3'd1;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_to_timeout(output int cnt, output logic aq, output logic am);
        cnt = 0;
        aq = 1'b0;
        am = 1'b0;
        while (cnt < 40) begin
            aq = alerta_quarto;
            am = alerta_meio;
            step();
            cnt++;
            if (timeout) break;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out"}, 32'({conta, zera_s, alerta_quarto, alerta_meio, pronto, timeout, fim_jogo}), 0);
        chk({tag, "_est"}, 32'(estouros), 0);
        chk({tag, "_db"}, 32'(db_estado), 0);
    endtask

    initial begin
        step();
        step();
        chk_idle("reset");
        reset = 1'b0;
        step();
        chk("idle_db", 32'(db_estado), 0);

        // in-time play at Q=2
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("prep_zera", 32'({zera_s, conta}), 2);
        chk("prep_db", 32'(db_estado), 1);
        step();
        chk("cont_entry", 32'({conta, q}), 32'h8);
        step();
        step();
        chk("q_at_play", 32'(q), 2);
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        chk("acerto_pt", 32'({pronto, timeout}), 2);
        chk("acerto_alerts", 32'({alerta_quarto, alerta_meio}), 2);
        chk("acerto_est", 32'(estouros), 0);
        step();
        chk("after_acerto", 32'({pronto, zera_s}), 1);
        step();
        chk("cont_again", 32'({conta, q}), 32'h8);
        chk("alerts_cleared", 32'({alerta_quarto, alerta_meio}), 0);

        // overrun 1
        run_to_timeout(n, aq_antes, am_antes);
        chk("ovr1_len", 32'(n), 8);
        chk("ovr1_timeout", 32'(timeout), 1);
        chk("ovr1_alerts_before", 32'({aq_antes, am_antes}), 3);
        chk("ovr1_est_during", 32'(estouros), 0);
        step();
        chk("ovr1_est", 32'(estouros), 1);
        chk("ovr1_prep", 32'({zera_s, timeout}), 2);
        step();

        // overruns 2 and 3 end the game
        run_to_timeout(n, aq_antes, am_antes);
        chk("ovr2_len", 32'(n), 8);
        step();
        chk("ovr2_est", 32'(estouros), 2);
        step();
        run_to_timeout(n, aq_antes, am_antes);
        chk("ovr3_len", 32'(n), 8);
        step();
        chk("gameover", 32'({fim_jogo, conta, zera_s}), 4);
        chk("gameover_est", 32'(estouros), 3);
        chk("gameover_db", 32'(db_estado), 15);
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        chk("gameover_hold", 32'({fim_jogo, pronto}), 2);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("restart_est", 32'(estouros), 0);
        chk("restart_prep", 32'({zera_s, fim_jogo}), 2);
        step();

        // jogada together with fim
        run_to_timeout(n, aq_antes, am_antes);
        step();
        chk("simul_pre_est", 32'(estouros), 1);
        step();
        repeat (7) step();
        chk("simul_fim", 32'({conta, fim}), 3);
        jogada = 1'b1;
        step();
        jogada = 1'b0;
        chk("simul_pt", 32'({pronto, timeout}), 2);
        step();
        chk("simul_est", 32'(estouros), 0);
        step();

        // pause for 5 cycles holding Q=3
        step();
        step();
        pausa = 1'b1;
        step();
        chk("pause_state", 32'({conta, db_estado}), 3);
        chk("pause_q", 32'(q), 3);
        jogada = 1'b1;
        repeat (4) begin
            step();
            chk("pause_hold", 32'({q, pronto, conta}), 32'h0C);
        end
        pausa = 1'b0;
        jogada = 1'b0;
        run_to_timeout(n, aq_antes, am_antes);
        chk("pause_total", 32'(n + 7), 13);
        step();
        chk("pause_est", 32'(estouros), 1);
        step();

        // reset mid-round at Q=5 with alerts set
        repeat (5) step();
        chk("pre_reset", 32'({q, alerta_quarto, alerta_meio}), 32'h17);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async_reset");
        step();
        reset = 1'b0;
        step();
        step();
        chk_idle("post_reset");
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("post_reset_start", 32'(db_estado), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/controle_tempo_jogada.md
# controle_tempo_jogada

Round-timing control unit that drives an external modulo-M time-base counter (`conta`, `zera_s`) and consumes its `fim`, `meio` and `quarto` flags.
- Each round opens a response window and reports either an in-time play (`pronto`) or a window overrun (`timeout`).
- Raises sticky quarter-time and half-time warnings during the window.
- Counts consecutive overruns and ends the game after `MAX_ESTOUROS` of them.
- Sits between the game's main control unit and the round counter in the datapath.

## Interface
Parameters:
- `MAX_ESTOUROS`, default 3: consecutive overruns that end the game; must be ≥1.
- `NE`, default 2: width of the overrun counter; must satisfy 2^NE > `MAX_ESTOUROS`.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `iniciar` in 1: start or restart the game; level, sampled each edge.
- `jogada` in 1: player action; level, sampled each edge.
- `pausa` in 1: freeze the window while high.
- `fim` in 1: counter at terminal value M-1.
- `meio` in 1: counter at M/2-1.
- `quarto` in 1: counter at M/4-1.
- `conta` out 1: counter enable.
- `zera_s` out 1: counter synchronous clear.
- `alerta_quarto` out 1: sticky quarter-time warning.
- `alerta_meio` out 1: sticky half-time warning.
- `pronto` out 1: one-cycle in-time play pulse.
- `timeout` out 1: one-cycle overrun pulse.
- `fim_jogo` out 1: game over; level.
- `estouros` out NE: current consecutive overrun count.
- `db_estado` out 4: state code, for debug.

## Operation
FSM states and transitions (first matching condition wins):
- `INICIAL`: `iniciar` → `PREPARA`.
- `PREPARA`: unconditional → `CONTANDO`.
- `CONTANDO`:
  - `jogada` → `ACERTO`.
  - else `fim` → `ESTOURO`.
  - else `pausa` → `PAUSADO`.
  - otherwise stay.
- `PAUSADO`: `!pausa` → `CONTANDO`. `jogada` and `fim` are ignored here.
- `ACERTO`: unconditional → `PREPARA`.
- `ESTOURO`: unconditional → `PREPARA`, or → `FIM_JOGO` if the incremented `estouros` equals `MAX_ESTOUROS`.
- `FIM_JOGO`: `iniciar` → `PREPARA`.

Moore outputs, decoded combinationally from state:
- `zera_s`=1 only in `PREPARA`.
- `conta`=1 only in `CONTANDO`.
- `pronto`=1 only in `ACERTO`.
- `timeout`=1 only in `ESTOURO`.
- `fim_jogo`=1 only in `FIM_JOGO`.

Warnings:
- Registered and sticky.
- `alerta_quarto` sets on an edge where state=`CONTANDO` and `quarto`=1; `alerta_meio` likewise with `meio`.
- Both clear on any edge where state=`PREPARA`.

`estouros` register:
- +1 on the edge leaving `ESTOURO`.
- Cleared on the edge leaving `ACERTO`.
- Cleared on `iniciar` accepted in `INICIAL` or `FIM_JOGO`.
- Saturates at `MAX_ESTOUROS`; never wraps.

Precedence rules:
- `jogada` beats `fim` in the same cycle: the round counts as in time.
- `jogada` beats `pausa` in the same cycle.
- `iniciar` outside `INICIAL`/`FIM_JOGO` has no effect.

Reset:
- Asserting `reset` at any time forces state=`INICIAL`, `estouros`=0 and both alerts=0 asynchronously.
- With no state-dependent exception, all outputs read 0 during and after reset, including `conta`, `zera_s` and `db_estado`=0.

## Timing
- `iniciar` sampled high at edge k → `PREPARA` in cycle k+1 → counter cleared at edge k+2 → `CONTANDO` from cycle k+2, with `conta`=1 and counter Q=0.
- An unpaused window lasts exactly M cycles in `CONTANDO`. `fim` seen at Q=M-1 → `ESTOURO` for 1 cycle → `PREPARA` for 1 cycle. The counter wraps to 0 on the same edge, which is harmless because `PREPARA` clears it.
- Play at any cycle of the window → `ACERTO` next cycle with `pronto` high for 1 cycle, then `PREPARA`.
- Pause latency is 1 cycle: `conta` drops in the cycle after `pausa` is first sampled, and Q holds. On resume, counting continues from the held Q.
- Alerts are visible the cycle after the counter flag is sampled.
- `estouros` updates 1 cycle after the `timeout` pulse.

State codes (from the package): `INICIAL`=0, `PREPARA`=1, `CONTANDO`=2, `PAUSADO`=3, `ACERTO`=4, `ESTOURO`=5, `FIM_JOGO`=15.

## Structure
- Shared package: 4-bit state code constants and the `db_estado` width constant.
- Single module with three blocks: state register plus next-state logic, output decode, and the alert/overrun register block.
- No sub-module. The counter is instantiated beside this block in the datapath, not inside it.

## Test plan
Bench instantiates this block wired to a modulo-8 counter, `MAX_ESTOUROS`=3.
- **In-time play:** `iniciar` pulse, then `jogada` at Q=2 → `pronto` 1 cycle, `alerta_quarto`=1, `alerta_meio`=0, `estouros`=0, back in `CONTANDO` with Q=0 two cycles later.
- **Overrun:** no play → `timeout` exactly 8 `CONTANDO` cycles after entry, alerts both 1 before `timeout`, `estouros`=1.
- **Game over:** three consecutive overruns → `fim_jogo`=1 with `estouros`=3 and `conta`=0. Then `iniciar` → `estouros`=0, new round.
- **Simultaneous flags:** `jogada` asserted in the cycle `fim`=1 → `pronto`, no `timeout`, `estouros` cleared.
- **Pause:** `pausa` for 5 cycles at Q=3 → Q holds 3, `jogada` ignored, `timeout` delayed by exactly 5 cycles versus an unpaused run.
- **Reset mid-round:** `reset` pulse at Q=5 with alerts set → all outputs 0, `db_estado`=0, `INICIAL` until `iniciar`.
